bell_round_ctrl: RTL and testbench

- N-player successor to the two-player bell game datapath (judge / first-press / score / winner).
- Per round:
  - arbitrates the first bell press among NUM_PLAYERS keys;
  - judges the face-up cards against TARGET;
  - updates saturating signed per-player scores;
  - declares a champion once one player leads every other player by more than WIN_MARGIN.
- Sits between the keypad/bell decoder and the LCD/segment display driver.

---
 rtl/bell_round_ctrl_if.sv | 36 +++
 rtl/bell_round_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bell_round_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bell_round_ctrl_if.sv
// Bus between the keypad/bell decoder (master) and bell_round_ctrl (slave).
// Card and score vectors are flat, player i owning slice i.
interface bell_round_ctrl_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 8,
  parameter int NUM_W       = 3,
  parameter int COLOR_W     = 2
);
  localparam int PID_W = $clog2(NUM_PLAYERS);

  logic                           game_clr;
  logic [NUM_PLAYERS-1:0]         bell_in;
  logic [NUM_PLAYERS-1:0]         card_valid;
  logic [NUM_PLAYERS*COLOR_W-1:0] card_color;
  logic [NUM_PLAYERS*NUM_W-1:0]   card_num;
  logic [SCORE_W-1:0]             pot_count;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic                           result_valid;
  logic                           result_right;
  logic [PID_W-1:0]               winner_id;
  logic                           busy;
  logic                           game_over;
  logic [PID_W-1:0]               champion_id;

  // No ready/valid backpressure: bells are level inputs sampled every cycle, and
  // result_valid is a one-cycle pulse the display side must take when it appears.
  modport master (
    output game_clr, bell_in, card_valid, card_color, card_num, pot_count,
    input  score, result_valid, result_right, winner_id, busy, game_over, champion_id
  );

  modport slave (
    input  game_clr, bell_in, card_valid, card_color, card_num, pot_count,
    output score, result_valid, result_right, winner_id, busy, game_over, champion_id
  );
endinterface

// File: rtl/bell_round_ctrl.sv
// N-player bell round controller: first-press arbitration, card judge, saturating scores, champion.
// Optional ROUND_ROBIN_TIE_EN: rotating tie priority instead of lowest-index-wins.
module bell_round_ctrl #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 8,
  parameter int NUM_W       = 3,
  parameter int COLOR_W     = 2,
  parameter int TARGET      = 5,
  parameter int WIN_MARGIN  = 50,
  parameter int PENALTY     = 1
) (
  input  logic               clk,
  input  logic               rst,
  bell_round_ctrl_if.slave   bus,
  output logic [2:0]         dbg_state_o
);
  localparam int PID_W = $clog2(NUM_PLAYERS);
  localparam int SUM_W = NUM_W + $clog2(NUM_PLAYERS);
  localparam int SW    = SCORE_W + 2;
  localparam int NCOL  = 1 << COLOR_W;

  localparam logic signed [SW-1:0] S_MAX   = {3'b000, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN   = {3'b111, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SW-1:0] PEN_ONE = SW'(PENALTY);
  localparam logic signed [SW-1:0] PEN_ALL = SW'(PENALTY * (NUM_PLAYERS - 1));
  localparam logic signed [SW-1:0] MARGIN  = SW'(WIN_MARGIN);

  typedef enum logic [2:0] {IDLE, JUDGE, AWARD, HOLD, DONE} state_t;

  state_t state_q, state_d;

  logic [NUM_PLAYERS-1:0]              prev_q;
  logic [PID_W-1:0]                    win_q;
  logic [NUM_PLAYERS-1:0]              cv_q;
  logic [NUM_PLAYERS-1:0][COLOR_W-1:0] cc_q;
  logic [NUM_PLAYERS-1:0][NUM_W-1:0]   cn_q;
  logic [SCORE_W-1:0]                  pot_q;
  logic                                right_q;
  logic                                rv_q;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q;
  logic [PID_W-1:0]                    champ_q;

  logic [NUM_PLAYERS-1:0]              ring;
  logic                                any_ring;
  logic [PID_W-1:0]                    pick;
  logic [SUM_W-1:0]                    sum;
  logic                                right_now;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_nxt;
  logic signed [SW-1:0]                cur;
  logic signed [SW-1:0]                val;
  logic signed [SW-1:0]                pot_ext;
  logic signed [SW-1:0]                s_w [NUM_PLAYERS];
  logic                                lead_all;
  logic                                champ_hit;
  logic [PID_W-1:0]                    champ_idx;

  function automatic logic [SCORE_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > S_MAX)      return S_MAX[SCORE_W-1:0];
    else if (v < S_MIN) return S_MIN[SCORE_W-1:0];
    else                return v[SCORE_W-1:0];
  endfunction

  assign ring     = bus.bell_in & ~prev_q;
  assign any_ring = |ring;

`ifdef ROUND_ROBIN_TIE_EN
  logic [PID_W-1:0] rr_q;
  logic [PID_W:0]   rr_idx;
  logic [PID_W:0]   rr_nxt;
  logic             rr_found;

  // Scan from the pointer upwards, wrapping modulo NUM_PLAYERS.
  always_comb begin
    pick     = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      rr_idx = {1'b0, rr_q} + (PID_W+1)'(k);
      if (rr_idx >= (PID_W+1)'(NUM_PLAYERS)) rr_idx = rr_idx - (PID_W+1)'(NUM_PLAYERS);
      if (!rr_found && ring[rr_idx[PID_W-1:0]]) begin
        pick     = rr_idx[PID_W-1:0];
        rr_found = 1'b1;
      end
    end
    rr_nxt = {1'b0, pick} + (PID_W+1)'(1);
    if (rr_nxt >= (PID_W+1)'(NUM_PLAYERS)) rr_nxt = '0;
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (ring[i]) pick = PID_W'(i);
    end
  end
`endif

  always_comb begin
    right_now = 1'b0;
    sum       = '0;
    for (int c = 0; c < NCOL; c++) begin
      sum = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (cv_q[i] && cc_q[i] == COLOR_W'(c)) sum = sum + SUM_W'(cn_q[i]);
      end
      if (sum == SUM_W'(TARGET)) right_now = 1'b1;
    end
  end

  // All score arithmetic is widened by two bits so saturation sees the true result.
  always_comb begin
    score_nxt = score_q;
    cur       = '0;
    val       = '0;
    pot_ext   = signed'({2'b00, pot_q});
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cur = SW'(signed'(score_q[i]));
      if (right_q) val = (PID_W'(i) == win_q) ? cur + pot_ext : cur;
      else         val = (PID_W'(i) == win_q) ? cur - PEN_ALL : cur + PEN_ONE;
      score_nxt[i] = sat(val);
    end
  end

  always_comb begin
    champ_hit = 1'b0;
    champ_idx = '0;
    lead_all  = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) s_w[i] = SW'(signed'(score_q[i]));
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      lead_all = 1'b1;
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j != i && !(s_w[i] > s_w[j] + MARGIN)) lead_all = 1'b0;
      end
      if (lead_all) begin
        champ_hit = 1'b1;
        champ_idx = PID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               state_q <= IDLE;
    else if (bus.game_clr) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_ring) state_d = JUDGE;
      JUDGE:   state_d = AWARD;
      AWARD:   state_d = HOLD;
      HOLD:    if (champ_hit) state_d = DONE;
               else if (bus.bell_in == '0) state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.game_over    = (state_q == DONE);
    bus.result_valid = rv_q;
    bus.result_right = right_q;
    bus.winner_id    = win_q;
    bus.champion_id  = champ_q;
    bus.score        = score_q;
    dbg_state_o      = state_q;
  end

  // Edge-detect history starts at all ones so a bell held across a clear never rings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '1;
      win_q   <= '0;
      cv_q    <= '0;
      cc_q    <= '0;
      cn_q    <= '0;
      pot_q   <= '0;
      right_q <= 1'b0;
      rv_q    <= 1'b0;
      score_q <= '0;
      champ_q <= '0;
`ifdef ROUND_ROBIN_TIE_EN
      rr_q    <= '0;
`endif
    end else if (bus.game_clr) begin
      prev_q  <= '1;
      win_q   <= '0;
      cv_q    <= '0;
      cc_q    <= '0;
      cn_q    <= '0;
      pot_q   <= '0;
      right_q <= 1'b0;
      rv_q    <= 1'b0;
      score_q <= '0;
      champ_q <= '0;
`ifdef ROUND_ROBIN_TIE_EN
      rr_q    <= '0;
`endif
    end else begin
      prev_q <= bus.bell_in;
      rv_q   <= (state_q == AWARD);
      case (state_q)
        IDLE: if (any_ring) begin
          win_q <= pick;
          cv_q  <= bus.card_valid;
          cc_q  <= bus.card_color;
          cn_q  <= bus.card_num;
          pot_q <= bus.pot_count;
`ifdef ROUND_ROBIN_TIE_EN
          rr_q  <= rr_nxt[PID_W-1:0];
`endif
        end
        JUDGE: right_q <= right_now;
        AWARD: score_q <= score_nxt;
        HOLD:  if (champ_hit) champ_q <= champ_idx;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bell_round_ctrl.sv
// Self-checking bench for bell_round_ctrl: directed rounds plus randomized rounds
// against a score/judge model built from the game rules.
module tb_bell_round_ctrl;
  localparam int NP = 4;
  localparam int SW = 8;
  localparam int NW = 3;
  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  bell_round_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .NUM_W(NW), .COLOR_W(CW)) bus ();

  bell_round_ctrl #(.NUM_PLAYERS(NP), .SCORE_W(SW), .NUM_W(NW), .COLOR_W(CW),
                    .TARGET(5), .WIN_MARGIN(50), .PENALTY(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          t_col [NP];
  int          t_num [NP];
  logic [NP-1:0] t_val;
  int          t_pot;

  int m_score [NP];
  int m_rr;
  bit m_over;
  logic [2:0] exp_q [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_score(input int i);
    logic [SW-1:0] s;
    s = bus.score[i*SW +: SW];
    return int'($signed(s));
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    m_rr   = 0;
    m_over = 1'b0;
  endfunction

  task automatic model_round(input logic [NP-1:0] mask, output int w, output bit r);
    int tot [4];
    w = -1;
`ifdef ROUND_ROBIN_TIE_EN
    for (int k = 0; k < NP; k++)
      if (w < 0 && mask[(m_rr + k) % NP]) w = (m_rr + k) % NP;
    m_rr = (w + 1) % NP;
`else
    for (int i = 0; i < NP; i++)
      if (w < 0 && mask[i]) w = i;
`endif
    for (int c = 0; c < 4; c++) tot[c] = 0;
    for (int i = 0; i < NP; i++)
      if (t_val[i]) tot[t_col[i]] += t_num[i];
    r = 1'b0;
    for (int c = 0; c < 4; c++) if (tot[c] == 5) r = 1'b1;
    for (int i = 0; i < NP; i++) begin
      if (r) begin
        if (i == w) m_score[i] = clamp(m_score[i] + t_pot);
      end else begin
        if (i == w) m_score[i] = clamp(m_score[i] - (NP - 1));
        else        m_score[i] = clamp(m_score[i] + 1);
      end
    end
  endtask

  function automatic bit model_champ(output int who);
    bit ok;
    who = 0;
    for (int i = 0; i < NP; i++) begin
      ok = 1'b1;
      for (int j = 0; j < NP; j++)
        if (j != i && !(m_score[i] > m_score[j] + 50)) ok = 1'b0;
      if (ok) begin
        who = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic drive_cards();
    for (int i = 0; i < NP; i++) begin
      bus.card_color[i*CW +: CW] = CW'(t_col[i]);
      bus.card_num[i*NW +: NW]   = NW'(t_num[i]);
    end
    bus.card_valid = t_val;
    bus.pot_count  = SW'(t_pot);
  endtask

  task automatic set_cards(input int c0, n0, c1, n1, c2, n2, c3, n3, input int pot);
    t_col[0] = c0; t_num[0] = n0;
    t_col[1] = c1; t_num[1] = n1;
    t_col[2] = c2; t_num[2] = n2;
    t_col[3] = c3; t_num[3] = n3;
    t_val = '1;
    t_pot = pot;
  endtask

  task automatic check_scores(input string tag);
    for (int i = 0; i < NP; i++) check_eq($sformatf("%s_score%0d", tag, i), dut_score(i), m_score[i]);
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < NP; i++) check_eq($sformatf("%s_score%0d", tag, i), dut_score(i), 0);
    check_eq({tag, "_rv"},    int'(bus.result_valid), 0);
    check_eq({tag, "_right"}, int'(bus.result_right), 0);
    check_eq({tag, "_win"},   int'(bus.winner_id), 0);
    check_eq({tag, "_busy"},  int'(bus.busy), 0);
    check_eq({tag, "_over"},  int'(bus.game_over), 0);
    check_eq({tag, "_champ"}, int'(bus.champion_id), 0);
    check_eq({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // One full round: press, await result, check champion, optionally hold other bells, release.
  task automatic run_round(input string tag, input logic [NP-1:0] mask,
                           input logic [NP-1:0] hold_mask, input int hold_cycles);
    int w, lat, who;
    bit r, got, champ;
    logic [2:0] e;
    drive_cards();
    @(posedge clk); #1;
    bus.bell_in = mask;
    model_round(mask, w, r);
    exp_q.push_back({r, 2'(w)});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (bus.result_valid) got = 1'b1;
    end
    check_eq({tag, "_latency"}, lat, 3);
    e = exp_q.pop_front();
    check_eq({tag, "_right"}, int'(bus.result_right), int'(e[2]));
    check_eq({tag, "_winner"}, int'(bus.winner_id), int'(e[1:0]));
    check_scores(tag);
    @(posedge clk); #1;
    check_eq({tag, "_rv_pulse"}, int'(bus.result_valid), 0);
    champ = model_champ(who);
    check_eq({tag, "_over"}, int'(bus.game_over), int'(champ));
    if (champ) begin
      check_eq({tag, "_champ_id"}, int'(bus.champion_id), who);
      m_over = 1'b1;
    end
    bus.bell_in = hold_mask;
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_busy"}, int'(bus.busy), 1);
      check_eq({tag, "_hold_win"}, int'(bus.winner_id), int'(e[1:0]));
    end
    bus.bell_in = '0;
    @(posedge clk); #1;
    check_eq({tag, "_busy_after"}, int'(bus.busy), int'(champ));
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    bus.game_clr = 1'b1;
    @(posedge clk); #1;
    bus.game_clr = 1'b0;
    model_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] m;
    int n0;
    rst          = 1'b1;
    bus.game_clr = 1'b0;
    bus.bell_in  = '0;
    set_cards(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cards();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset");

    // Correct press: red 2+3 = 5.
    set_cards(0, 2, 0, 3, 1, 4, 2, 1, 6);
    run_round("right", 4'b0100, '0, 0);
    check_eq("right_p2_six", dut_score(2), 6);

    // Wrong press from a clean game.
    pulse_clr();
    set_cards(0, 2, 1, 2, 2, 1, 0, 1, 6);
    run_round("wrong", 4'b0010, '0, 0);
    check_eq("wrong_p1", dut_score(1), -3);
    check_eq("wrong_p0", dut_score(0), 1);

    // Tie, held bell blocks IDLE, P0 press during HOLD dropped; repeat tie; then P0.
    pulse_clr();
    set_cards(0, 2, 0, 3, 1, 4, 2, 1, 3);
    run_round("tie1", 4'b1010, 4'b1001, 3);
    run_round("tie2", 4'b1010, '0, 0);
    run_round("p0", 4'b0001, '0, 0);

    // Saturation high: climb everyone to 120 in steps that never open a 50 lead.
    pulse_clr();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) begin
        set_cards(0, 2, 0, 3, 1, 4, 2, 1, 40);
        run_round("climb", 4'(1 << p), '0, 0);
      end
    set_cards(0, 2, 0, 3, 1, 4, 2, 1, 20);
    run_round("sat_hi", 4'b0001, '0, 0);
    check_eq("sat_hi_p0", dut_score(0), 127);

    // Saturation low: P0 keeps pressing wrongly.
    pulse_clr();
    set_cards(0, 2, 1, 2, 2, 1, 0, 1, 0);
    for (int k = 0; k < 43; k++) run_round("sink", 4'b0001, '0, 0);
    check_eq("sat_lo_p0", dut_score(0), -128);

    // Champion, then bells ignored, then game_clr.
    pulse_clr();
    for (int p = 1; p < NP; p++) begin
      set_cards(0, 2, 0, 3, 1, 4, 2, 1, 9);
      run_round("pre", 4'(1 << p), '0, 0);
    end
    set_cards(0, 2, 0, 3, 1, 4, 2, 1, 60);
    run_round("champ", 4'b0001, '0, 0);
    check_eq("champ_over", int'(bus.game_over), 1);
    check_eq("champ_id0", int'(bus.champion_id), 0);
    bus.bell_in = 4'b0010;
    repeat (4) @(posedge clk);
    #1;
    bus.bell_in = '0;
    check_eq("done_still_over", int'(bus.game_over), 1);
    check_scores("done_frozen");
    pulse_clr();
    check_cleared("clr");

    // Async reset during JUDGE with a bell held across the release.
    set_cards(0, 2, 0, 3, 1, 4, 2, 1, 7);
    drive_cards();
    @(posedge clk); #1;
    bus.bell_in = 4'b0100;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_cleared("async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("held_no_ring", int'(bus.busy), 0);
    end
    bus.bell_in = '0;
    run_round("after_rst", 4'b0100, '0, 0);

    // Randomized rounds.
    pulse_clr();
    for (int n = 0; n < 40; n++) begin
      if (m_over) pulse_clr();
      for (int i = 0; i < NP; i++) begin
        t_col[i] = int'($urandom_range(0, 3));
        t_num[i] = int'($urandom_range(0, 7));
      end
      t_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        n0 = int'($urandom_range(0, 5));
        t_col[0] = 0; t_num[0] = n0;
        t_col[1] = 0; t_num[1] = 5 - n0;
        t_val[1:0] = 2'b11;
      end
      t_pot = (n % 5 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
      m = 4'($urandom_range(1, 15));
      run_round("rand", m, '0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
